keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex keypad and turns each debounced key press into a 4-bit hex code. Each accepted digit is shifted into a 16-bit value register. It is the input-side counterpart of the multiplexed seven-segment display driver: it drives columns one at a time and reads rows back. Its `value` output feeds the display driver's `inval` directly, so typed digits appear on the display.

## Interface
Parameters:
- `SCAN_DIV`, default 16384: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE`, default 4: consecutive identical frames required to accept a press or a release; must be ≥ 1.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `row`  in  4: keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col`  out  4: column drive, one-hot active-low (0 = driven).
- `key_valid`  out  1: one-cycle pulse when a press is accepted.
- `key_code`  out  4: hex code of the last accepted key; held between pulses.
- `value`  out  16: last four accepted digits, most recent in `[3:0]`.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- **Column scanning**
  - A column counter (0..3) advances every `SCAN_DIV` cycles and wraps from 3 to 0.
  - `col` = ~(1 << column).
- **Row sampling**
  - Synchronized rows are sampled on the last cycle of each column period, after `SCAN_DIV`-1 cycles of settling.
  - The sample is stored as 4 bits of a 16-bit frame snapshot; bit `4*c+r` is set when row r reads low while column c is driven.
- **Frame classification**
  - A frame is complete when the column 3 sample is taken.
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set, at position k.
  - MULTI: two or more bits set.
- **Key map** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Debounce FSM**, evaluated once per completed frame; `cnt` counts consecutive qualifying frames.
- IDLE:
  - SINGLE(k): latch candidate k, cnt=1, go to CONFIRM. If `DEBOUNCE`=1, accept immediately and go to HELD.
  - NONE or MULTI: stay in IDLE.
- CONFIRM:
  - SINGLE(same k): cnt++. When cnt reaches `DEBOUNCE`, accept and go to HELD.
  - SINGLE(other k): restart with the new candidate, cnt=1.
  - NONE or MULTI: go to IDLE.
- HELD:
  - Any non-NONE frame, including MULTI or a different key: cnt=0, stay in HELD. No auto-repeat and no rollover.
  - NONE: cnt=1, go to RELEASE.
- RELEASE:
  - NONE: cnt++. When cnt reaches `DEBOUNCE`, go to IDLE.
  - Any non-NONE frame: go to HELD.
- **Accept**
  - `key_code` <= map(k).
  - `value` <= {value[11:0], map(k)}.
  - `key_valid` = 1 for exactly one cycle.
- Only one press is accepted per physical press-and-release.

## Timing
- Reset values:
  - `col`=4'b1110 (column 0)
  - `key_valid`=0, `key_code`=0, `value`=16'h0000
  - FSM in IDLE, cnt=0, snapshot=0, column divider=0
  - Synchronizer flops = 4'b1111
- Reset mid-scan or mid-debounce discards all partial state. No key is emitted until `DEBOUNCE` full frames after deassertion.
- Frame period: 4·`SCAN_DIV` cycles.
- Column changes occur on the cycle after the sample cycle.
- `key_valid`, `key_code` and `value` update together, registered on the cycle after the column 3 sample of the accepting frame.
- Press-to-pulse latency is at most (`DEBOUNCE`+1)·4·`SCAN_DIV` + 3 cycles, counted from the row level change.
- `key_code` and `value` are stable except on the `key_valid` cycle.
- A `value` overflow past 4 digits silently discards the oldest digit.

## Structure
- Package `keypad_pkg`: FSM state enum (IDLE, CONFIRM, HELD, RELEASE), the 16-entry key map constant, and the frame-class enum (NONE, SINGLE, MULTI).
- Sub-module `keypad_debounce`: FSM, cnt and candidate logic. It takes the snapshot plus a frame-done strobe and emits accept, code and a key_valid strobe.
- The top level contains the synchronizer, column divider, snapshot capture and `value` shift register.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE`=2, so one frame is 16 cycles.
- **Reset**: hold `rst_n`=0 with `row` random → `col`=1110, `key_valid`=0, `value`=0000. After release, `col` steps 1110→1101→1011→0111 every 4 cycles and wraps.
- **Single press**: model key '5' (row1 pulled low while col1 is driven) for 5 frames, then release for 3 frames → exactly one `key_valid` pulse, `key_code`=5, `value`=0005.
- **Sequence**: press and release 1, 2, 3, A, F in turn → five pulses; `value` ends at 23AF.
- **Bounce**: key '7' present for 1 frame, absent for 1 frame, repeated 4 times → no pulse. A stable press afterwards gives one pulse with `key_code`=7.
- **Multi-key**: press 1 and 2 together for 6 frames → no pulse. While '0' is held, add 'D' → still only the single pulse for 0, no second pulse.
- **Reset mid-debounce**: assert `rst_n`=0 during CONFIRM for 'C' → no pulse and `value`=0000. Holding 'C' afterwards pulses once after 2 frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM/frame enums, hex key map and snapshot helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_e;
  // Nibble k (k = 4*col + row) holds the hex code of that key
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;
  function automatic frame_e classify(input logic [15:0] s);
    return (s == '0) ? NONE : ((s & (s - 16'd1)) == '0) ? SINGLE : MULTI;
  endfunction
  function automatic logic [3:0] key_index(input logic [15:0] s);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) if (s[i]) k = 4'(i);
    return k;
  endfunction
  function automatic logic [3:0] key_map(input logic [3:0] k);
    return KEY_MAP[{k, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-frame press/release debounce FSM emitting one accept per physical press
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done,
  input  logic [15:0] snap,
  output logic        accept,
  output logic [3:0]  code,
  output logic        key_valid,
  output logic [3:0]  key_code
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  cand_q, cand_d, k;
  logic        key_valid_q, key_valid_d, done_cnt;
  logic [3:0]  key_code_q, key_code_d;
  frame_e      fclass;
  always_comb begin
    fclass   = classify(snap);
    k        = key_index(snap);
    code     = key_map(k);
    cnt_inc  = cnt_q + CW'(1);
    done_cnt = cnt_inc == CW'(DEBOUNCE);
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept   = 1'b0;
    if (frame_done) begin
      case (state_q)
        IDLE: if (fclass == SINGLE) begin
          cand_d  = k;
          cnt_d   = CW'(1);
          accept  = DEBOUNCE == 1;
          state_d = (DEBOUNCE == 1) ? HELD : CONFIRM;
        end
        CONFIRM: if (fclass == SINGLE && k == cand_q) begin
          cnt_d   = done_cnt ? '0 : cnt_inc;
          accept  = done_cnt;
          state_d = done_cnt ? HELD : CONFIRM;
        end else if (fclass == SINGLE) begin
          cand_d = k;
          cnt_d  = CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        HELD: if (fclass == NONE) begin
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE == 1) ? IDLE : RELEASE;
        end else begin
          cnt_d = '0;
        end
        RELEASE: if (fclass == NONE) begin
          cnt_d   = done_cnt ? '0 : cnt_inc;
          state_d = done_cnt ? IDLE : RELEASE;
        end else begin
          cnt_d   = '0;
          state_d = HELD;
        end
        default: state_d = IDLE;
      endcase
    end
    key_valid_d = accept;
    key_code_d  = accept ? code : key_code_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scanner with debounced digit entry into a 16-bit value
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16384,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [15:0]   snap_q, snap_d, value_q, value_d;
  logic          sample, frame_done, accept;
  logic [3:0]    code;
  always_comb begin
    sample     = div_q == DW'(SCAN_DIV - 1);
    frame_done = sample && col_idx_q == 2'd3;
    div_d      = sample ? '0 : div_q + DW'(1);
    col_idx_d  = col_idx_q + {1'b0, sample};
    snap_d     = snap_q;
    if (sample) snap_d[{col_idx_q, 2'b00} +: 4] = ~row_s2_q;
    value_d    = accept ? {value_q[11:0], code} : value_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      div_q     <= '0;
      col_idx_q <= '0;
      snap_q    <= '0;
      value_q   <= '0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      snap_q    <= snap_d;
      value_q   <= value_d;
    end
  end
  // The debouncer sees the completed frame including the column 3 sample taken this cycle
  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_done(frame_done),
    .snap      (snap_d),
    .accept    (accept),
    .code      (code),
    .key_valid (key_valid),
    .key_code  (key_code)
  );
  assign col   = ~(4'b0001 << col_idx_q);
  assign value = value_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven checks of keypad_scanner with a behavioural keypad model
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid;
  logic [15:0] value;
  logic [15:0] pressed = '0;
  int checks = 0, errors = 0, pulses = 0;

  typedef struct {
    logic [15:0] keys;
    int          press_f;
    int          rel_f;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic [15:0] exp_value;
  } vec_t;
  vec_t vecs[7];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code), .value(value)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key at (r,c) pulls row r low while column c is driven
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) if (!col[c]) row = row & ~pressed[4*c +: 4];
  end

  always @(negedge clk) if (rst_n && key_valid) pulses++;

  initial begin
    #300000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  initial begin
    int p0, n;
    logic [3:0] e;
    vecs[0] = '{16'h0020, 5, 3, 1, 4'h5, 16'h0005};
    vecs[1] = '{16'h0001, 4, 3, 1, 4'h1, 16'h0051};
    vecs[2] = '{16'h0010, 4, 3, 1, 4'h2, 16'h0512};
    vecs[3] = '{16'h0100, 4, 3, 1, 4'h3, 16'h5123};
    vecs[4] = '{16'h1000, 4, 3, 1, 4'hA, 16'h123A};
    vecs[5] = '{16'h0080, 4, 3, 1, 4'hF, 16'h23AF};
    vecs[6] = '{16'h0011, 6, 3, 0, 4'hF, 16'h23AF};

    pressed = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_key_code", key_code, 0);
    pressed = '0;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((i / 4) % 4));
      chk("col_step", col, e);
    end

    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      pressed = vecs[i].keys;
      wait_frames(vecs[i].press_f);
      pressed = '0;
      wait_frames(vecs[i].rel_f);
      chk($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
      chk($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
    end

    p0 = pulses;
    repeat (4) begin
      pressed = 16'h0004;
      wait_frames(1);
      pressed = '0;
      wait_frames(1);
    end
    chk("bounce_pulses", pulses - p0, 0);
    pressed = 16'h0004;
    wait_frames(5);
    pressed = '0;
    wait_frames(3);
    chk("bounce_stable_pulses", pulses - p0, 1);
    chk("bounce_code", key_code, 4'h7);
    chk("bounce_value", value, 16'h3AF7);

    p0 = pulses;
    pressed = 16'h0008;
    wait_frames(4);
    pressed = 16'h8008;
    wait_frames(4);
    pressed = '0;
    wait_frames(3);
    chk("rollover_pulses", pulses - p0, 1);
    chk("rollover_code", key_code, 4'h0);
    chk("rollover_value", value, 16'hAF70);

    p0 = pulses;
    pressed = 16'h0400;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < 200);
    chk("latency_seen", key_valid, 1);
    chk("latency_bound", n <= 51, 1);
    pressed = '0;
    wait_frames(3);
    chk("latency_pulses", pulses - p0, 1);
    chk("latency_code", key_code, 4'h9);
    chk("latency_value", value, 16'hF709);

    n = 0;
    while (col !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    chk("align", n < 100, 1);
    p0 = pulses;
    pressed = 16'h4000;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_value", value, 0);
    chk("midrst_col", col, 4'b1110);
    chk("midrst_code", key_code, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < 100);
    chk("midrst_latency", n, 32);
    chk("midrst_pulse_code", key_code, 4'hC);
    chk("midrst_pulse_value", value, 16'h000C);
    pressed = '0;
    wait_frames(3);
    chk("midrst_pulses", pulses - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
